fifo_stream_reader: RTL

- Read-side master for the team's synchronous FIFO interface (`fifo_if` read port).
- Drains FIFO words and presents them on a valid/ready output stream (`m_*`) in order, at up to one word per cycle.
- Must never pop an empty FIFO. Must tolerate arbitrary `m_ready` backpressure without losing or duplicating data.
- Sits between any `fifo_if` FIFO and downstream pipeline consumers.

---
 rtl/fifo_stream_reader.sv | 102 ++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side master feeding a valid/ready output stream
//
// Purpose:
//   Pops words from a synchronous FIFO (data valid the cycle after the pop)
//   and presents them in order on a valid/ready stream through a 2-entry
//   skid buffer. It sustains one word per cycle and never pops an empty FIFO.
//
// Ports:
//   clk           system clock, all logic on posedge
//   rst_n         synchronous active-low reset
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    pop request to FIFO
//   fifo_rd_data  FIFO read data, valid the cycle after an accepted pop
//   m_valid       output word valid
//   m_ready       downstream accepts word
//   m_data        output word (0 while idle)
//   flush         discard all buffered and in-flight words
//   busy          m_valid or a pop in flight
//   words_out     count of completed output handshakes (wraps)

module fifo_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_out
);

  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_cnt;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_words;

  logic                  w_out_pop;
  logic [1:0]            w_rem;
  logic [2:0]            w_credit;

  assign m_valid   = (r_cnt != 2'd0);
  assign m_data    = m_valid ? r_buf0 : '0;
  assign busy      = m_valid || r_inflight;
  assign words_out = r_words;

  assign w_out_pop = m_valid && m_ready;

  // Entries left after this cycle's handshake; capture lands right behind them.
  assign w_rem = r_cnt - {1'b0, w_out_pop};

  // Slots committed after this cycle: everything buffered or in flight, minus
  // the word leaving now. A new pop is allowed only if a slot stays free.
  assign w_credit = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_out_pop};

  assign fifo_rd_en = rst_n && !flush && !fifo_empty && (w_credit < 3'd2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_cnt      <= 2'd0;
      r_inflight <= 1'b0;
      r_words    <= '0;
    end else begin
      // fifo_rd_en already folds in !fifo_empty and !flush, so it is the pop.
      r_inflight <= fifo_rd_en;

      if (w_out_pop) begin
        r_words <= r_words + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end

      if (flush) begin
        r_buf0 <= '0;
        r_buf1 <= '0;
        r_cnt  <= 2'd0;
      end else begin
        r_cnt <= w_rem + {1'b0, r_inflight};

        if (w_out_pop) begin
          r_buf0 <= r_buf1;
        end

        // Placed after the shift so a capture into an emptied head wins.
        if (r_inflight) begin
          if (w_rem == 2'd0) begin
            r_buf0 <= fifo_rd_data;
          end else begin
            r_buf1 <= fifo_rd_data;
          end
        end
      end
    end
  end

endmodule
